memblk_port_arb: RTL and testbench

//  Shares one memblk read/write port pair among NREQ requesters with round-robin arbitration.

---
 rtl/memblk_port_arb.sv | 197 +++++++++++++++++++
 tb/tb_memblk_port_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memblk_port_arb.sv
// memblk_port_arb: round-robin arbiter sharing one memblk read/write port pair
// among NREQ requesters. Reads carry a requester-ID tag through a LAT-deep
// pipeline that advances in lockstep with memblk. Each response is steered
// back to the requester that issued the read. Per-requester credit counters
// bound the number of outstanding reads.
//
// Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i].
// req_ready is a one-hot grant and is computed combinationally each cycle.
// The requester must hold valid, we, addr and wdata stable until it is granted.
// Responses have no backpressure. rsp_valid is a one-cycle one-hot pulse, and
// rsp_data is broadcast to all requesters.
module memblk_port_arb #(
    parameter int NREQ   = 8,
    parameter int ADDR_W = 37,
    parameter int DATA_W = 533,
    parameter int LAT    = 48,
    parameter int MAXOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     mem_stall,
    output logic                     mem_rden,
    output logic [ADDR_W-1:0]        mem_rdaddr,
    output logic                     mem_wren,
    output logic [ADDR_W-1:0]        mem_wraddr,
    output logic [DATA_W-1:0]        mem_wrdata,
    input  logic                     mem_rden_out,
    input  logic [DATA_W-1:0]        mem_rddata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     err_orphan
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(MAXOUT + 1);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q [NREQ];
    logic [CW-1:0]     cnt_d [NREQ];
    tag_t              tag_q [LAT];
    tag_t              tag_d [LAT];
    logic              mem_rden_q, mem_rden_d;
    logic              mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0] mem_rdaddr_q, mem_rdaddr_d;
    logic [ADDR_W-1:0] mem_wraddr_q, mem_wraddr_d;
    logic [DATA_W-1:0] mem_wrdata_q, mem_wrdata_d;
    logic [IDW-1:0]    rd_id_q, rd_id_d;
    logic              err_orphan_q, err_orphan_d;

    logic [NREQ-1:0]   elig;
    logic              grant_any;
    logic [IDW-1:0]    grant_idx;
    logic              grant_we;
    int                scan_idx;
    tag_t              tag_last;

    // Round-robin scan from ptr for the first eligible requester; no grant while stalled or in reset
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] & (req_we[i] | (cnt_q[i] < CW'(MAXOUT)));
        end
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        if (!mem_stall && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = int'(ptr_q) + k;
                if (scan_idx >= NREQ) begin
                    scan_idx = scan_idx - NREQ;
                end
                if (!grant_any && elig[IDW'(scan_idx)]) begin
                    grant_any = 1'b1;
                    grant_idx = IDW'(scan_idx);
                end
            end
        end
        req_ready = grant_any ? (NREQ'(1) << grant_idx) : '0;
        grant_we  = req_we[grant_idx];
    end

    // Pointer advance and issue register; every memblk-facing output holds while stalled
    always_comb begin
        ptr_d        = ptr_q;
        mem_rden_d   = mem_rden_q;
        mem_wren_d   = mem_wren_q;
        mem_rdaddr_d = mem_rdaddr_q;
        mem_wraddr_d = mem_wraddr_q;
        mem_wrdata_d = mem_wrdata_q;
        rd_id_d      = rd_id_q;
        if (grant_any) begin
            ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
        if (!mem_stall) begin
            mem_rden_d = grant_any & ~grant_we;
            mem_wren_d = grant_any & grant_we;
            if (grant_any && !grant_we) begin
                mem_rdaddr_d = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                rd_id_d      = grant_idx;
            end
            if (grant_any && grant_we) begin
                mem_wraddr_d = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                mem_wrdata_d = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
            end
        end
    end

    // Tag pipe follows memblk: stage 0 captures the read actually presented; a stall freezes it
    always_comb begin
        tag_d = tag_q;
        if (!mem_stall) begin
            tag_d[0].valid = mem_rden_q;
            tag_d[0].id    = rd_id_q;
            for (int s = 1; s < LAT; s++) begin
                tag_d[s] = tag_q[s-1];
            end
        end
    end

    // Response steering and orphan detection from the oldest tag
    always_comb begin
        tag_last     = tag_q[LAT-1];
        rsp_valid    = (mem_rden_out && tag_last.valid) ? (NREQ'(1) << tag_last.id) : '0;
        err_orphan_d = err_orphan_q
                     | (mem_rden_out & ~tag_last.valid)
                     | (tag_last.valid & ~mem_rden_out & ~mem_stall);
    end

    // Credit counters: one taken per read grant, one returned per response; saturating at both ends
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (req_ready[i] && !req_we[i] && !rsp_valid[i]) begin
                if (cnt_q[i] < CW'(MAXOUT)) begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else if (rsp_valid[i] && !(req_ready[i] && !req_we[i])) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            mem_rden_q   <= 1'b0;
            mem_wren_q   <= 1'b0;
            mem_rdaddr_q <= '0;
            mem_wraddr_q <= '0;
            mem_wrdata_q <= '0;
            rd_id_q      <= '0;
            err_orphan_q <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            mem_rden_q   <= mem_rden_d;
            mem_wren_q   <= mem_wren_d;
            mem_rdaddr_q <= mem_rdaddr_d;
            mem_wraddr_q <= mem_wraddr_d;
            mem_wrdata_q <= mem_wrdata_d;
            rd_id_q      <= rd_id_d;
            err_orphan_q <= err_orphan_d;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign mem_rden   = mem_rden_q;
    assign mem_wren   = mem_wren_q;
    assign mem_rdaddr = mem_rdaddr_q;
    assign mem_wraddr = mem_wraddr_q;
    assign mem_wrdata = mem_wrdata_q;
    assign rsp_data   = mem_rddata;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_memblk_port_arb.sv
// Directed bench for memblk_port_arb with a small memblk read-latency model
// and an expected-response queue.
module tb_memblk_port_arb;

  localparam int NREQ   = 8;
  localparam int ADDR_W = 37;
  localparam int DATA_W = 533;
  localparam int LAT    = 48;
  localparam int MAXOUT = 4;
  localparam int EW     = NREQ + ADDR_W;

  typedef logic [DATA_W-1:0] dw_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_we = '0;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic                   mem_stall = 1'b0;
  logic                   mem_rden;
  logic [ADDR_W-1:0]      mem_rdaddr;
  logic                   mem_wren;
  logic [ADDR_W-1:0]      mem_wraddr;
  logic [DATA_W-1:0]      mem_wrdata;
  logic                   mem_rden_out;
  logic [DATA_W-1:0]      mem_rddata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic                   err_orphan;

  logic [ADDR_W-1:0]      a_arr [NREQ];
  logic [DATA_W-1:0]      w_arr [NREQ];
  logic                   orphan_force = 1'b0;

  logic [EW-1:0]          exp_q [$];
  logic [EW-1:0]          mon_e;
  int                     n_chk = 0;
  int                     n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_addr[g*ADDR_W +: ADDR_W]  = a_arr[g];
    assign req_wdata[g*DATA_W +: DATA_W] = w_arr[g];
  end

  memblk_port_arb #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT), .MAXOUT(MAXOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .mem_stall(mem_stall),
    .mem_rden(mem_rden), .mem_rdaddr(mem_rdaddr),
    .mem_wren(mem_wren), .mem_wraddr(mem_wraddr), .mem_wrdata(mem_wrdata),
    .mem_rden_out(mem_rden_out), .mem_rddata(mem_rddata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_orphan(err_orphan)
  );

  // memblk model: LAT-deep read pipe that advances only when not stalled;
  // read data is the zero-extended read address
  logic              m_v [LAT];
  logic [ADDR_W-1:0] m_a [LAT];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        m_v[i] <= 1'b0;
        m_a[i] <= '0;
      end
    end else if (!mem_stall) begin
      m_v[0] <= mem_rden;
      m_a[0] <= mem_rdaddr;
      for (int i = 1; i < LAT; i++) begin
        m_v[i] <= m_v[i-1];
        m_a[i] <= m_a[i-1];
      end
    end
  end

  assign mem_rden_out = (m_v[LAT-1] & ~mem_stall) | orphan_force;
  assign mem_rddata   = dw_t'(m_a[LAT-1]);

  // scoreboard
  task automatic chk(input string tag, input dw_t obs, input dw_t exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i] && !req_we[i]) begin
          exp_q.push_back({NREQ'(1) << i, a_arr[i]});
        end
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", dw_t'(rsp_valid), '0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_onehot", dw_t'(rsp_valid), dw_t'(mon_e[EW-1:ADDR_W]));
          chk("rsp_data", rsp_data, dw_t'(mon_e[ADDR_W-1:0]));
        end
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_we = '0;
    mem_stall = 1'b0;
    orphan_force = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    repeat (n) cyc();
    settle();
    chk("drain_queue_empty", dw_t'(exp_q.size()), '0);
    chk("drain_no_orphan", dw_t'(err_orphan), '0);
  endtask

  logic [NREQ-1:0]   exp_r;
  int                gcount;
  logic [DATA_W-1:0] wpat;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      w_arr[i] = '0;
    end

    // ready must stay low while in reset even with every requester valid
    req_valid = '1;
    #1;
    chk("rst_ready_low", dw_t'(req_ready), '0);

    // reset state
    do_reset();
    settle();
    chk("rst_rden", dw_t'(mem_rden), '0);
    chk("rst_wren", dw_t'(mem_wren), '0);
    chk("rst_rdaddr", dw_t'(mem_rdaddr), '0);
    chk("rst_wraddr", dw_t'(mem_wraddr), '0);
    chk("rst_wrdata", mem_wrdata, '0);
    chk("rst_err", dw_t'(err_orphan), '0);
    chk("rst_rsp", dw_t'(rsp_valid), '0);
    chk("rst_ready_idle", dw_t'(req_ready), '0);

    // 1. single read and its response LAT+1 cycles after grant
    a_arr[0] = 37'h100;
    req_we = '0;
    req_valid = 8'h01;
    settle();
    chk("t1_grant", dw_t'(req_ready), dw_t'(8'h01));
    cyc();
    req_valid = '0;
    settle();
    chk("t1_rden", dw_t'(mem_rden), dw_t'(1'b1));
    chk("t1_rdaddr", dw_t'(mem_rdaddr), dw_t'(37'h100));
    chk("t1_wren", dw_t'(mem_wren), '0);
    repeat (47) cyc();
    settle();
    chk("t1_rsp_early", dw_t'(rsp_valid), '0);
    cyc();
    settle();
    chk("t1_rsp", dw_t'(rsp_valid), dw_t'(8'h01));
    chk("t1_rsp_data", rsp_data, dw_t'(37'h100));
    cyc();
    // credit returned: four more reads fit, the fifth does not
    req_valid = 8'h01;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("t1_credit_%0d", k), dw_t'(req_ready), (k < 4) ? dw_t'(8'h01) : '0);
      cyc();
    end
    drain(60);

    // 2. round-robin across all requesters until every credit is used
    do_reset();
    for (int i = 0; i < NREQ; i++) a_arr[i] = ADDR_W'(37'h200 + i);
    req_we = '0;
    req_valid = '1;
    for (int k = 0; k < 52; k++) begin
      settle();
      if (k < 32) exp_r = NREQ'(1) << (k % 8);
      else if (k == 50) exp_r = 8'h01;
      else if (k == 51) exp_r = 8'h02;
      else exp_r = '0;
      chk($sformatf("t2_rr_%0d", k), dw_t'(req_ready), dw_t'(exp_r));
      cyc();
    end
    drain(60);

    // 3. credit limit on a single streaming requester
    do_reset();
    a_arr[3] = 37'h300;
    req_we = '0;
    req_valid = 8'h08;
    gcount = 0;
    for (int k = 0; k < 51; k++) begin
      settle();
      if (k < 50 && req_ready[3]) gcount++;
      chk($sformatf("t3_ready_%0d", k), dw_t'(req_ready),
          (k < 4 || k == 50) ? dw_t'(8'h08) : '0);
      cyc();
    end
    chk("t3_grant_count", dw_t'(gcount), dw_t'(MAXOUT));
    drain(60);

    // 4. five-cycle stall in the middle of a read stream
    do_reset();
    req_we = '0;
    for (int k = 0; k < 59; k++) begin
      a_arr[5] = ADDR_W'(37'h500 + k);
      mem_stall = (k >= 2 && k <= 6);
      req_valid = (k <= 7) ? 8'h20 : 8'h00;
      settle();
      if (k < 10) begin
        chk($sformatf("t4_ready_%0d", k), dw_t'(req_ready),
            (k < 2 || k == 7) ? dw_t'(8'h20) : '0);
      end
      if (k >= 2 && k <= 6) begin
        chk($sformatf("t4_hold_rden_%0d", k), dw_t'(mem_rden), dw_t'(1'b1));
        chk($sformatf("t4_hold_addr_%0d", k), dw_t'(mem_rdaddr), dw_t'(37'h501));
      end
      if (k >= 50) begin
        chk($sformatf("t4_rsp_%0d", k), dw_t'(rsp_valid),
            (k >= 54 && k <= 56) ? dw_t'(8'h20) : '0);
      end
      if (k == 54) chk("t4_data_0", rsp_data, dw_t'(37'h500));
      if (k == 55) chk("t4_data_1", rsp_data, dw_t'(37'h501));
      if (k == 56) chk("t4_data_2", rsp_data, dw_t'(37'h507));
      cyc();
    end
    mem_stall = 1'b0;
    drain(10);

    // 5. write/read mix with ptr at 1; writes take no credit
    do_reset();
    wpat = '1;
    wpat[40:0] = 41'h1_2345_6789;
    req_we = 8'h01;
    a_arr[0] = 37'h0AA;
    req_valid = 8'h01;
    settle();
    chk("t5_w0_grant", dw_t'(req_ready), dw_t'(8'h01));
    cyc();
    req_we = 8'h02;
    a_arr[1] = 37'h111;
    w_arr[1] = wpat;
    a_arr[2] = 37'h222;
    req_valid = 8'h06;
    settle();
    chk("t5_write_first", dw_t'(req_ready), dw_t'(8'h02));
    cyc();
    req_we = '0;
    a_arr[1] = 37'h1A0;
    settle();
    chk("t5_read_next", dw_t'(req_ready), dw_t'(8'h04));
    chk("t5_wren", dw_t'(mem_wren), dw_t'(1'b1));
    chk("t5_wraddr", dw_t'(mem_wraddr), dw_t'(37'h111));
    chk("t5_wrdata", mem_wrdata, wpat);
    chk("t5_no_rden", dw_t'(mem_rden), '0);
    cyc();
    req_valid = 8'h02;
    settle();
    chk("t5_rden", dw_t'(mem_rden), dw_t'(1'b1));
    chk("t5_rdaddr", dw_t'(mem_rdaddr), dw_t'(37'h222));
    chk("t5_wren_off", dw_t'(mem_wren), '0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) settle();
      chk($sformatf("t5_credit_%0d", k), dw_t'(req_ready), (k < 4) ? dw_t'(8'h02) : '0);
      cyc();
    end
    drain(60);

    // 6. orphan response sets a sticky error
    do_reset();
    settle();
    chk("t6_err_before", dw_t'(err_orphan), '0);
    orphan_force = 1'b1;
    settle();
    chk("t6_rsp_none", dw_t'(rsp_valid), '0);
    cyc();
    orphan_force = 1'b0;
    settle();
    chk("t6_err_set", dw_t'(err_orphan), dw_t'(1'b1));
    repeat (5) cyc();
    settle();
    chk("t6_err_sticky", dw_t'(err_orphan), dw_t'(1'b1));
    chk("t6_rsp_still_none", dw_t'(rsp_valid), '0);
    do_reset();
    settle();
    chk("t6_err_cleared", dw_t'(err_orphan), '0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
